// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0]  FWD_RF    = 2'b00;
  localparam logic [1:0]  FWD_MEM   = 2'b01;
  localparam logic [1:0]  FWD_WB    = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select for one source register; MEM result beats WB result.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwen,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwen,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwen && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwen && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables, flushes, EX forwarding,
// data-memory wait FSM with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwen,
  input  logic             ex_is_load,
  input  logic             ex_pcsel,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwen,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwen,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze;
  logic              err_set;
  logic              load_use;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  forward_unit u_fwd_a (
    .rs         (ex_rs1),
    .mem_rd     (mem_rd),
    .mem_regwen (mem_regwen),
    .wb_rd      (wb_rd),
    .wb_regwen  (wb_regwen),
    .sel        (fwd_a_raw)
  );

  forward_unit u_fwd_b (
    .rs         (ex_rs2),
    .mem_rd     (mem_rd),
    .mem_regwen (mem_regwen),
    .wb_rd      (wb_rd),
    .wb_regwen  (wb_regwen),
    .sel        (fwd_b_raw)
  );

  // Memory wait FSM: freeze is high on every cycle the whole pipe must hold
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    freeze    = 1'b0;
    err_set   = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = '0;
          freeze    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = RUN;
          wait_nxt  = '0;
          err_set   = 1'b1;
        end else begin
          wait_nxt  = wait_cnt + 1'b1;
          freeze    = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  assign load_use = ex_is_load && ex_regwen && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Branch flush outranks load-use: the stalled ID instruction is wrong-path
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (!rst && !freeze) begin
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      id_ex_en  = 1'b1;
      if (ex_pcsel) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        mem_err <= 1'b1;
      end
      if (!pc_en) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (ex_pcsel && !freeze) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             ex_regwen, ex_is_load, ex_pcsel, mem_regwen, mem_req, dmem_ready, wb_regwen;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: outstanding access and frozen cycles so far
  int m_stall = 0;
  int m_flush = 0;
  bit m_err   = 1'b0;
  bit m_busy  = 1'b0;
  int m_frozen = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_is_load(ex_is_load), .ex_pcsel(ex_pcsel),
    .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input logic [4:0] rs);
    if (mem_regwen && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_regwen && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  always @(negedge clk) begin
    logic [6:0] exp_ctl;
    logic [6:0] act_ctl;
    bit frz, tmo, lu;
    frz = 1'b0;
    tmo = 1'b0;
    if (!rst) begin
      if (m_busy) begin
        if (!dmem_ready) begin
          if (m_frozen >= MEM_TIMEOUT) tmo = 1'b1;
          else frz = 1'b1;
        end
      end else if (mem_req && !dmem_ready) begin
        frz = 1'b1;
      end
    end
    lu = ex_is_load && ex_regwen && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (rst || frz)     exp_ctl = 7'b0000000;
    else if (ex_pcsel)  exp_ctl = 7'b1111111;
    else if (lu)        exp_ctl = 7'b0001111;
    else                exp_ctl = 7'b1101011;
    act_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    chk("model_ctl", int'(act_ctl), int'(exp_ctl));
    chk("model_fwd_a", int'(fwd_a), rst ? 0 : exp_fwd(ex_rs1));
    chk("model_fwd_b", int'(fwd_b), rst ? 0 : exp_fwd(ex_rs2));
    chk("model_stall_cnt", int'(stall_cnt), m_stall);
    chk("model_flush_cnt", int'(flush_cnt), m_flush);
    chk("model_mem_err", int'(mem_err), int'(m_err));
    if (rst) begin
      m_stall = 0; m_flush = 0; m_err = 1'b0; m_busy = 1'b0; m_frozen = 0;
    end else begin
      if (!exp_ctl[6] && m_stall < CMAX) m_stall++;
      if (ex_pcsel && !frz && m_flush < CMAX) m_flush++;
      if (tmo) m_err = 1'b1;
      if (frz) begin
        m_busy = 1'b1;
        m_frozen++;
      end else begin
        m_busy = 1'b0;
        m_frozen = 0;
      end
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_regwen = 0; ex_is_load = 0; ex_pcsel = 0; mem_regwen = 0;
    mem_req = 0; dmem_ready = 0; wb_regwen = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    nxt();
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_regwen = 1; ex_rd = 7; id_rs2 = 7;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ex_pcsel = 1;
    nxt();
    @(negedge clk);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    nxt();
    rst = 1'b0;
    idle();

    // forwarding priority and x0
    ex_rd = 5; ex_regwen = 1; mem_rd = 5; mem_regwen = 1; wb_rd = 5; wb_regwen = 1; ex_rs1 = 5;
    @(negedge clk);
    chk("fwd_a_mem", fwd_a, 1);
    nxt();
    mem_regwen = 0; ex_rs2 = 5;
    @(negedge clk);
    chk("fwd_b_wb", fwd_b, 2);
    nxt();
    idle();
    mem_rd = 0; mem_regwen = 1; wb_rd = 0; wb_regwen = 1; ex_rs1 = 0;
    @(negedge clk);
    chk("fwd_a_x0", fwd_a, 0);

    // load-use: one bubble
    nxt();
    do_reset();
    set_load_use();
    @(negedge clk);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_ex_mem_en", ex_mem_en, 1);
    nxt();
    idle();
    ex_is_load = 1; ex_regwen = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("lu_x0_pc_en", pc_en, 1);
    chk("lu_stall_cnt", stall_cnt, 1);

    // branch with load-use present
    nxt();
    do_reset();
    set_load_use();
    ex_pcsel = 1;
    @(negedge clk);
    chk("br_pc_en", pc_en, 1);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    nxt();
    idle();
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);

    // 3-cycle memory wait with a held branch
    nxt();
    do_reset();
    mem_req = 1; ex_pcsel = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_frozen_pc_en", pc_en, 0);
      chk("mw_frozen_flush", if_id_flush, 0);
      nxt();
    end
    dmem_ready = 1;
    @(negedge clk);
    chk("mw_release_mem_wb_en", mem_wb_en, 1);
    chk("mw_release_flush", if_id_flush, 1);
    nxt();
    idle();
    @(negedge clk);
    chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_flush_cnt", flush_cnt, 1);

    // timeout
    nxt();
    do_reset();
    mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      chk("to_frozen_pc_en", pc_en, 0);
      nxt();
    end
    @(negedge clk);
    chk("to_advance_pc_en", pc_en, 1);
    chk("to_err_before", mem_err, 0);
    nxt();
    idle();
    @(negedge clk);
    chk("to_mem_err", mem_err, 1);
    chk("to_stall_cnt", stall_cnt, MEM_TIMEOUT);
    nxt();
    nxt();
    @(negedge clk);
    chk("to_err_sticky", mem_err, 1);
    nxt();
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", mem_err, 0);

    // saturation
    nxt();
    set_load_use();
    repeat (20) nxt();
    idle();
    ex_pcsel = 1;
    repeat (20) nxt();
    idle();
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 15);

    // reset in the middle of a wait
    nxt();
    mem_req = 1;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rmw_pc_en", pc_en, 1);
    chk("rmw_stall_cnt", stall_cnt, 0);
    chk("rmw_flush_cnt", flush_cnt, 0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
